// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACCEPT = 2'd1,
        ST_WAIT_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] UART_IDLE_STA = 4'd0;
    localparam int DEFAULT_TIMEOUT_CYCLES = 262144;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional per-frame watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ID_W           = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 uart_send,
    output logic [7:0]           uart_send_data,
    input  logic [3:0]           uart_send_sta,
    input  logic                 uart_send_done,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id,
    output logic                 frame_done,
    output logic                 err_timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 uart_send_q, uart_send_d;
    logic [7:0]           data_q, data_d;
    logic                 busy_q, busy_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_timeout_q, err_timeout_d;

    logic                 gnt_valid;
    logic [ID_W-1:0]      gnt_id;
    logic                 capture;
    logic                 timeout_hit;
    logic [7:0]           req_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[8*gi +: 8];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req       (req_valid),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign capture = (state_q == ST_IDLE) && gnt_valid;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (capture) begin
            cnt_d = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed busy cycles since capture; expire on the last one.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_ack_d     = '0;
        uart_send_d   = uart_send_q;
        data_d        = data_q;
        busy_d        = busy_q;
        cur_id_d      = cur_id_q;
        last_d        = last_q;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                uart_send_d = 1'b0;
                if (gnt_valid) begin
                    req_ack_d[gnt_id[IDX_W-1:0]] = 1'b1;
                    data_d      = req_bytes[gnt_id[IDX_W-1:0]];
                    cur_id_d    = gnt_id;
                    last_d      = gnt_id;
                    busy_d      = 1'b1;
                    uart_send_d = 1'b1;
                    state_d     = ST_WAIT_ACCEPT;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (uart_send_sta != UART_IDLE_STA) begin
                    uart_send_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    uart_send_d   = 1'b0;
                    busy_d        = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                uart_send_d = 1'b0;
                if (uart_send_sta == UART_IDLE_STA && uart_send_done) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if (timeout_hit) begin
                    busy_d        = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                uart_send_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_ack_q     <= '0;
            uart_send_q   <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            cur_id_q      <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ack_q     <= req_ack_d;
            uart_send_q   <= uart_send_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            cur_id_q      <= cur_id_d;
            last_q        <= last_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ack        = req_ack_q;
    assign uart_send      = uart_send_q;
    assign uart_send_data = data_q;
    assign busy           = busy_q;
    assign cur_id         = cur_id_q;
    assign frame_done     = frame_done_q;
    assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table plus multi-cycle scenarios.
module tb_uart_tx_sched;
    localparam int NR  = 4;
    localparam int IDW = 3;
    localparam int TO  = 1000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_ack;
    logic            uart_send;
    logic [7:0]      uart_send_data;
    logic [3:0]      uart_send_sta;
    logic            uart_send_done;
    logic            busy;
    logic [IDW-1:0]  cur_id;
    logic            frame_done;
    logic            err_timeout;

    uart_tx_sched #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .ID_W           (IDW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ack        (req_ack),
        .uart_send      (uart_send),
        .uart_send_data (uart_send_data),
        .uart_send_sta  (uart_send_sta),
        .uart_send_done (uart_send_done),
        .busy           (busy),
        .cur_id         (cur_id),
        .frame_done     (frame_done),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] byte_q [$];
    int         ack_q [$];
    int         fd_cnt  = 0;
    int         to_cnt  = 0;
    bit         stuck   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic bound_fail(input string name, input int bound);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen within %0d cycles (expected it)", name, bound);
    endtask

    // UART model: loads on send, stays busy a few cycles, then pulses done.
    initial begin
        int m_st;
        int m_cnt;
        m_st = 0;
        m_cnt = 0;
        uart_send_sta  = 4'd0;
        uart_send_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                uart_send_sta  = 4'd0;
                uart_send_done = 1'b0;
                m_st = 0;
            end else begin
                case (m_st)
                    0: begin
                        uart_send_done = 1'b0;
                        if (uart_send && !stuck) begin
                            uart_send_sta = 4'd1;
                            byte_q.push_back(uart_send_data);
                            m_cnt = 4;
                            m_st  = 1;
                        end
                    end
                    1: begin
                        if (m_cnt == 0) begin
                            uart_send_sta  = 4'd0;
                            uart_send_done = 1'b1;
                            m_st = 2;
                        end else begin
                            m_cnt--;
                        end
                    end
                    default: begin
                        uart_send_done = 1'b0;
                        m_st = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: record acks and pulses, and require one-hot acks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (req_ack != '0) begin
                    check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
                    for (int i = 0; i < NR; i++) if (req_ack[i]) ack_q.push_back(i);
                end
                if (frame_done)  fd_cnt++;
                if (err_timeout) to_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input int bound, output int id, output int cyc);
        id  = -1;
        cyc = 0;
        while (cyc < bound) begin
            tick();
            cyc++;
            if (req_ack != '0) begin
                for (int i = 0; i < NR; i++) if (req_ack[i]) id = i;
                return;
            end
        end
        bound_fail("wait_ack", bound);
    endtask

    task automatic wait_frame_done(input int bound);
        for (int c = 0; c < bound; c++) begin
            tick();
            if (frame_done) return;
        end
        bound_fail("wait_frame_done", bound);
    endtask

    task automatic wait_idle(input int bound);
        for (int c = 0; c < bound; c++) begin
            tick();
            if (!busy) return;
        end
        bound_fail("wait_idle", bound);
    endtask

    typedef struct {
        logic [NR-1:0]   valid;
        logic [8*NR-1:0] data;
        int              exp_id;
        logic [7:0]      exp_byte;
    } vec_t;

    vec_t vecs [8];

    int exp_fair_id [5] = '{0, 1, 2, 3, 0};
    int exp_fair_b  [5] = '{'h10, 'h21, 'h32, 'h43, 'h10};
    int exp_mid_id  [3] = '{1, 3, 1};
    int exp_mid_b   [3] = '{'h11, 'h33, 'h11};

    initial begin
        int id;
        int cyc;
        int fd0;
        int to0;

        // Pointer walk starting from reset (last = 3).
        vecs[0] = '{4'b0100, 32'h11A52233, 2, 8'hA5};
        vecs[1] = '{4'b0011, 32'h44332211, 0, 8'h11};
        vecs[2] = '{4'b1001, 32'h5A6B7C8D, 3, 8'h5A};
        vecs[3] = '{4'b1001, 32'h5A6B7C8D, 0, 8'h8D};
        vecs[4] = '{4'b0010, 32'hDEADBEEF, 1, 8'hBE};
        vecs[5] = '{4'b1110, 32'hCAFEF00D, 2, 8'hFE};
        vecs[6] = '{4'b0001, 32'h0000007E, 0, 8'h7E};
        vecs[7] = '{4'b1000, 32'hFF000000, 3, 8'hFF};

        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) tick();
        check("reset_outputs",
              32'({req_ack, uart_send, uart_send_data, busy, cur_id, frame_done, err_timeout}), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            byte_q.delete();
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            wait_ack(20, id, cyc);
            check($sformatf("v%0d_ack_id", i), 32'(id), 32'(vecs[i].exp_id));
            if (i == 0) check("v0_latency", 32'(cyc), 32'd1);
            check($sformatf("v%0d_cur_id", i), 32'(cur_id), 32'(vecs[i].exp_id));
            check($sformatf("v%0d_send", i), 32'({uart_send, busy}), 32'b11);
            check($sformatf("v%0d_data", i), 32'(uart_send_data), 32'(vecs[i].exp_byte));
            req_valid = '0;
            wait_frame_done(50);
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_uart_byte", i),
                  byte_q.size() == 1 ? 32'(byte_q[0]) : 32'hFFFF, 32'(vecs[i].exp_byte));
        end

        // Fairness with all four held valid.
        ack_q.delete();
        byte_q.delete();
        req_data  = 32'h43322110;
        req_valid = 4'b1111;
        for (int c = 0; c <= 500; c++) begin
            if (byte_q.size() >= 5) break;
            if (c == 500) bound_fail("fair_bytes", 500);
            else tick();
        end
        req_valid = '0;
        wait_idle(100);
        tick();
        check("fair_ack_count", 32'(ack_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair_ack%0d", k), ack_q.size() > k ? 32'(ack_q[k]) : 32'hFFFF, 32'(exp_fair_id[k]));
            check($sformatf("fair_byte%0d", k), byte_q.size() > k ? 32'(byte_q[k]) : 32'hFFFF, 32'(exp_fair_b[k]));
        end

        // Requester 3 joins while requester 1 is being served.
        ack_q.delete();
        byte_q.delete();
        req_data  = 32'h33001100;
        req_valid = 4'b0010;
        wait_ack(20, id, cyc);
        req_valid = 4'b1010;
        for (int c = 0; c <= 300; c++) begin
            if (ack_q.size() >= 3) break;
            if (c == 300) bound_fail("mid_acks", 300);
            else tick();
        end
        req_valid = '0;
        wait_idle(100);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_ack%0d", k), ack_q.size() > k ? 32'(ack_q[k]) : 32'hFFFF, 32'(exp_mid_id[k]));
            check($sformatf("mid_byte%0d", k), byte_q.size() > k ? 32'(byte_q[k]) : 32'hFFFF, 32'(exp_mid_b[k]));
        end

        // Valid pulsed while the scheduler is busy is ignored.
        ack_q.delete();
        byte_q.delete();
        req_data  = 32'h000000C3;
        req_valid = 4'b0001;
        wait_ack(20, id, cyc);
        req_valid = '0;
        repeat (3) tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        wait_frame_done(50);
        repeat (10) tick();
        check("drop_ack_count", 32'(ack_q.size()), 32'd1);
        check("drop_byte_count", 32'(byte_q.size()), 32'd1);

        // Asynchronous reset while in WAIT_DONE.
        req_data  = 32'h00AB0000;
        req_valid = 4'b0100;
        wait_ack(20, id, cyc);
        check("rst_pre_ack_id", 32'(id), 32'd2);
        req_valid = '0;
        for (int c = 0; c <= 20; c++) begin
            if (uart_send_sta != 0 && !uart_send) break;
            if (c == 20) bound_fail("rst_wait_done", 20);
            else tick();
        end
        check("rst_pre_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outputs",
              32'({req_ack, uart_send, uart_send_data, busy, cur_id, frame_done, err_timeout}), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_no_send%0d", k), 32'(uart_send), 32'd0);
        end
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        wait_ack(20, id, cyc);
        check("rst_ptr_ack_id", 32'(id), 32'd0);
        check("rst_ptr_data", 32'(uart_send_data), 32'h11);
        req_valid = '0;
        wait_frame_done(50);
        tick();

        // UART stuck at idle status.
        stuck = 1'b1;
        fd0 = fd_cnt;
        to0 = to_cnt;
        req_data  = 32'h00005566;
        req_valid = 4'b0011;
        wait_ack(20, id, cyc);
        check("to_ack_id", 32'(id), 32'd1);
        req_valid = 4'b0001;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cyc = 0;
        while (cyc < 1100) begin
            tick();
            cyc++;
            if (err_timeout) break;
        end
        check("to_cycles", 32'(cyc), 32'(TO));
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        tick();
        check("to_next_ack", 32'(req_ack), 32'b0001);
        req_valid = '0;
        stuck = 1'b0;
        wait_frame_done(100);
        check("to_pulse_count", 32'(to_cnt - to0), 32'd1);
`else
        repeat (1100) tick();
        check("to_busy_held", 32'(busy), 32'd1);
        check("to_no_err", 32'(to_cnt - to0), 32'd0);
        req_valid = '0;
        stuck = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
